// File: rtl/qe_bus_sequencer.sv
// rtl/qe_bus_sequencer.sv - QL expansion bus to W5300 strobe sequencer with dtackl generation
module qe_bus_sequencer #(
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned STROBE_CYC  = 3,
    parameter int unsigned HOLD_CYC    = 1,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic       clk,
    input  logic       resetl,
    input  logic [9:0] address,
    input  logic       asl,
    input  logic       dsl,
    input  logic       rdwl,
    output logic       dtackl,
    output logic       dbenl,
    output logic       dbdir,
    output logic       wizcsl,
    output logic       wizrdl,
    output logic       wizwrl,
    output logic       wizrst_req,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_ACK, S_RELEASE
    } state_t;

    localparam logic [7:0] SETUP_LD   = 8'(SETUP_CYC - 1);
    localparam logic [7:0] STROBE_LD  = 8'(STROBE_CYC - 1);
    localparam logic [7:0] HOLD_LD    = 8'(HOLD_CYC - 1);
    localparam logic [7:0] TIMEOUT_LD = 8'(TIMEOUT_CYC - 1);

    state_t     state, state_next;
    logic [7:0] cnt, cnt_load;
    logic       as_m, as_s, ds_m, ds_s, ds_p, rw_m, rw_s;
    logic       rw_l, wiz_l, acked;
    logic       card, hit_wiz, hit_rst, accept;
    logic       dtack_drv;

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            as_m <= 1'b1; as_s <= 1'b1;
            ds_m <= 1'b1; ds_s <= 1'b1; ds_p <= 1'b1;
            rw_m <= 1'b1; rw_s <= 1'b1;
        end else begin
            as_m <= asl;  as_s <= as_m;
            ds_m <= dsl;  ds_s <= ds_m; ds_p <= ds_s;
            rw_m <= rdwl; rw_s <= rw_m;
        end
    end

    // Decode uses the raw address; it is stable while asl is low.
    always_comb begin
        card    = (address[9:4] == 6'b000100);
        hit_wiz = card && (address[3:0] == 4'h8);
        hit_rst = card && (address[3:0] == 4'hC);
        accept  = (state == S_IDLE) && ds_p && !ds_s && !as_s && card;
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (accept) state_next = hit_wiz ? S_SETUP : S_ACK;
            S_SETUP:   if (ds_s) state_next = S_RELEASE;
                       else if (cnt == 8'd0) state_next = S_STROBE;
            S_STROBE:  if (ds_s) state_next = S_RELEASE;
                       else if (cnt == 8'd0) state_next = rw_l ? S_ACK : S_HOLD;
            S_HOLD:    if (ds_s) state_next = S_RELEASE;
                       else if (cnt == 8'd0) state_next = S_ACK;
            S_ACK:     if (ds_s || cnt == 8'd0) state_next = S_RELEASE;
            S_RELEASE: if (cnt == 8'd0) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_load = 8'd0;
        case (state_next)
            S_SETUP:          cnt_load = SETUP_LD;
            S_STROBE:         cnt_load = STROBE_LD;
            S_HOLD, S_RELEASE: cnt_load = HOLD_LD;
            S_ACK:            cnt_load = TIMEOUT_LD;
            default:          cnt_load = 8'd0;
        endcase
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            cnt        <= 8'd0;
            rw_l       <= 1'b1;
            wiz_l      <= 1'b0;
            acked      <= 1'b0;
            timeout    <= 1'b0;
            wizrst_req <= 1'b0;
        end else begin
            if (state_next != state) begin
                cnt <= cnt_load;
            end else if (cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
            if (accept) begin
                rw_l  <= rw_s;
                wiz_l <= hit_wiz;
            end
            // acked marks a RELEASE that followed ACK rather than an abort.
            if (state == S_ACK) begin
                acked <= 1'b1;
            end else if (state == S_IDLE) begin
                acked <= 1'b0;
            end
            if (state == S_ACK && !ds_s && cnt == 8'd0) begin
                timeout <= 1'b1;
            end
            wizrst_req <= accept && hit_rst && !rw_s;
        end
    end

    always_comb begin
        dtack_drv = 1'b0;
        dbenl     = 1'b1;
        wizcsl    = 1'b1;
        wizrdl    = 1'b1;
        wizwrl    = 1'b1;
        busy      = (state != S_IDLE);
        case (state)
            S_SETUP: begin
                dbenl  = 1'b0;
                wizcsl = 1'b0;
            end
            S_STROBE: begin
                dbenl  = 1'b0;
                wizcsl = 1'b0;
                wizrdl = !rw_l;
                wizwrl = rw_l;
            end
            S_HOLD: begin
                dbenl  = 1'b0;
                wizcsl = 1'b0;
            end
            S_ACK: begin
                dbenl     = 1'b0;
                dtack_drv = 1'b1;
                wizcsl    = !(wiz_l && rw_l);
                wizrdl    = !(wiz_l && rw_l);
            end
            S_RELEASE: begin
                wizcsl = !(wiz_l && rw_l && acked);
            end
            default: begin
                dbenl = 1'b1;
            end
        endcase
        dbdir = dbenl ? 1'b1 : rw_l;
    end

    assign dtackl = dtack_drv ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_qe_bus_sequencer.sv
// tb/tb_qe_bus_sequencer.sv - directed self-checking bench for qe_bus_sequencer
module tb_qe_bus_sequencer;

    logic       clk = 1'b0;
    logic       resetl = 1'b0;
    logic [9:0] address = 10'h000;
    logic       asl = 1'b1;
    logic       dsl = 1'b1;
    logic       rdwl = 1'b1;
    wire        dtackl;
    logic       dbenl, dbdir, wizcsl, wizrdl, wizwrl, wizrst_req, busy, timeout;

    int total = 0;
    int bad = 0;

    logic [511:0] tr_dtk, tr_cs, tr_rd, tr_wr, tr_rq, tr_busy, tr_benl, tr_dir, tr_to;

    pullup (dtackl);

    qe_bus_sequencer dut (
        .clk(clk), .resetl(resetl), .address(address), .asl(asl), .dsl(dsl), .rdwl(rdwl),
        .dtackl(dtackl), .dbenl(dbenl), .dbdir(dbdir), .wizcsl(wizcsl), .wizrdl(wizrdl),
        .wizwrl(wizwrl), .wizrst_req(wizrst_req), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Index k of each trace holds the outputs seen after the k-th rising edge following the strobe drive.
    task automatic run_access(input logic [9:0] a, input logic rw, input int low_cyc, input int n);
        @(negedge clk);
        address = a; rdwl = rw; asl = 1'b0; dsl = 1'b0;
        tr_dtk = '1; tr_cs = '1; tr_rd = '1; tr_wr = '1; tr_rq = '0;
        tr_busy = '0; tr_benl = '1; tr_dir = '1; tr_to = '0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            tr_dtk[k] = dtackl; tr_cs[k] = wizcsl; tr_rd[k] = wizrdl; tr_wr[k] = wizwrl;
            tr_rq[k] = wizrst_req; tr_busy[k] = busy; tr_benl[k] = dbenl; tr_dir[k] = dbdir;
            tr_to[k] = timeout;
            if (k == low_cyc) begin
                dsl = 1'b1; asl = 1'b1;
            end
        end
        rdwl = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    function automatic int cnt_v(input logic [511:0] v, input int n, input logic val);
        int c = 0;
        for (int k = 1; k <= n; k++) if (v[k] === val) c++;
        return c;
    endfunction

    function automatic int first_v(input logic [511:0] v, input int n, input logic val);
        for (int k = 1; k <= n; k++) if (v[k] === val) return k;
        return -1;
    endfunction

    function automatic int last_v(input logic [511:0] v, input int n, input logic val);
        int r = -1;
        for (int k = 1; k <= n; k++) if (v[k] === val) r = k;
        return r;
    endfunction

    task automatic test_reset;
        logic [8:0] obs;
        repeat (2) @(negedge clk);
        obs = {dtackl, dbenl, dbdir, wizcsl, wizrdl, wizwrl, wizrst_req, busy, timeout};
        total++;
        if (obs !== 9'b111111000) begin
            bad++; $display("FAIL reset_outputs got=%b want=%b", obs, 9'b111111000);
        end
        resetl = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_wiz_write;
        run_access(10'h048, 1'b0, 20, 26);
        total++; if (first_v(tr_cs, 26, 1'b0) != 3) begin bad++; $display("FAIL wr_cs_first got=%0d want=3", first_v(tr_cs, 26, 1'b0)); end
        total++; if (cnt_v(tr_cs, 26, 1'b0) != 5) begin bad++; $display("FAIL wr_cs_len got=%0d want=5", cnt_v(tr_cs, 26, 1'b0)); end
        total++; if (first_v(tr_wr, 26, 1'b0) != 4) begin bad++; $display("FAIL wr_wr_first got=%0d want=4", first_v(tr_wr, 26, 1'b0)); end
        total++; if (cnt_v(tr_wr, 26, 1'b0) != 3) begin bad++; $display("FAIL wr_wr_len got=%0d want=3", cnt_v(tr_wr, 26, 1'b0)); end
        total++; if (first_v(tr_dtk, 26, 1'b0) != 8) begin bad++; $display("FAIL wr_dtack_first got=%0d want=8", first_v(tr_dtk, 26, 1'b0)); end
        total++; if (last_v(tr_dtk, 26, 1'b0) != 22) begin bad++; $display("FAIL wr_dtack_last got=%0d want=22", last_v(tr_dtk, 26, 1'b0)); end
        total++; if (cnt_v(tr_rd, 26, 1'b0) != 0) begin bad++; $display("FAIL wr_no_rd got=%0d want=0", cnt_v(tr_rd, 26, 1'b0)); end
        total++; if ({tr_benl[5], tr_dir[5]} !== 2'b00) begin bad++; $display("FAIL wr_buffer got=%b want=00", {tr_benl[5], tr_dir[5]}); end
        total++; if (last_v(tr_busy, 26, 1'b1) != 23) begin bad++; $display("FAIL wr_busy_last got=%0d want=23", last_v(tr_busy, 26, 1'b1)); end
    endtask

    task automatic test_wiz_read;
        run_access(10'h048, 1'b1, 20, 26);
        total++; if (first_v(tr_rd, 26, 1'b0) != 4) begin bad++; $display("FAIL rd_rd_first got=%0d want=4", first_v(tr_rd, 26, 1'b0)); end
        total++; if (last_v(tr_rd, 26, 1'b0) != 22) begin bad++; $display("FAIL rd_rd_last got=%0d want=22", last_v(tr_rd, 26, 1'b0)); end
        total++; if (last_v(tr_cs, 26, 1'b0) != 23) begin bad++; $display("FAIL rd_cs_last got=%0d want=23", last_v(tr_cs, 26, 1'b0)); end
        total++; if (first_v(tr_dtk, 26, 1'b0) != 7) begin bad++; $display("FAIL rd_dtack_first got=%0d want=7", first_v(tr_dtk, 26, 1'b0)); end
        total++; if (last_v(tr_dtk, 26, 1'b0) != 22) begin bad++; $display("FAIL rd_dtack_last got=%0d want=22", last_v(tr_dtk, 26, 1'b0)); end
        total++; if ({tr_benl[10], tr_dir[10]} !== 2'b01) begin bad++; $display("FAIL rd_buffer got=%b want=01", {tr_benl[10], tr_dir[10]}); end
        total++; if (cnt_v(tr_wr, 26, 1'b0) != 0) begin bad++; $display("FAIL rd_no_wr got=%0d want=0", cnt_v(tr_wr, 26, 1'b0)); end
    endtask

    task automatic test_reset_reg;
        run_access(10'h04C, 1'b0, 6, 12);
        total++; if (cnt_v(tr_rq, 12, 1'b1) != 1) begin bad++; $display("FAIL rstw_pulse_len got=%0d want=1", cnt_v(tr_rq, 12, 1'b1)); end
        total++; if (first_v(tr_rq, 12, 1'b1) != 3) begin bad++; $display("FAIL rstw_pulse_at got=%0d want=3", first_v(tr_rq, 12, 1'b1)); end
        total++; if (first_v(tr_dtk, 12, 1'b0) != 3) begin bad++; $display("FAIL rstw_dtack_first got=%0d want=3", first_v(tr_dtk, 12, 1'b0)); end
        total++; if (last_v(tr_dtk, 12, 1'b0) != 8) begin bad++; $display("FAIL rstw_dtack_last got=%0d want=8", last_v(tr_dtk, 12, 1'b0)); end
        total++; if (cnt_v(tr_cs, 12, 1'b0) != 0) begin bad++; $display("FAIL rstw_cs got=%0d want=0", cnt_v(tr_cs, 12, 1'b0)); end
        run_access(10'h04C, 1'b1, 6, 12);
        total++; if (cnt_v(tr_rq, 12, 1'b1) != 0) begin bad++; $display("FAIL rstr_pulse got=%0d want=0", cnt_v(tr_rq, 12, 1'b1)); end
        total++; if (first_v(tr_dtk, 12, 1'b0) != 3) begin bad++; $display("FAIL rstr_dtack_first got=%0d want=3", first_v(tr_dtk, 12, 1'b0)); end
    endtask

    task automatic test_non_card;
        int act;
        run_access(10'h148, 1'b1, 6, 12);
        act = cnt_v(tr_busy, 12, 1'b1) + cnt_v(tr_dtk, 12, 1'b0) + cnt_v(tr_cs, 12, 1'b0) + cnt_v(tr_benl, 12, 1'b0);
        total++; if (act != 0) begin bad++; $display("FAIL noncard_148 active_samples=%0d want=0", act); end
        run_access(10'h038, 1'b0, 6, 12);
        act = cnt_v(tr_busy, 12, 1'b1) + cnt_v(tr_dtk, 12, 1'b0) + cnt_v(tr_wr, 12, 1'b0) + cnt_v(tr_benl, 12, 1'b0);
        total++; if (act != 0) begin bad++; $display("FAIL noncard_038 active_samples=%0d want=0", act); end
    endtask

    task automatic test_abort;
        run_access(10'h048, 1'b0, 4, 10);
        total++; if (last_v(tr_wr, 10, 1'b0) != 6) begin bad++; $display("FAIL abort_wr_last got=%0d want=6", last_v(tr_wr, 10, 1'b0)); end
        total++; if (cnt_v(tr_dtk, 10, 1'b0) != 0) begin bad++; $display("FAIL abort_dtack got=%0d want=0", cnt_v(tr_dtk, 10, 1'b0)); end
        total++; if (last_v(tr_cs, 10, 1'b0) != 6) begin bad++; $display("FAIL abort_cs_last got=%0d want=6", last_v(tr_cs, 10, 1'b0)); end
        total++; if (last_v(tr_busy, 10, 1'b1) != 7) begin bad++; $display("FAIL abort_busy_last got=%0d want=7", last_v(tr_busy, 10, 1'b1)); end
    endtask

    task automatic test_timeout;
        run_access(10'h048, 1'b1, 400, 410);
        total++; if ({tr_to[261], tr_to[262]} !== 2'b01) begin bad++; $display("FAIL to_flag_edge got=%b want=01", {tr_to[261], tr_to[262]}); end
        total++; if (cnt_v(tr_dtk, 410, 1'b0) != 255) begin bad++; $display("FAIL to_dtack_cycles got=%0d want=255", cnt_v(tr_dtk, 410, 1'b0)); end
        total++; if (last_v(tr_busy, 410, 1'b1) != 262) begin bad++; $display("FAIL to_no_retrigger busy_last=%0d want=262", last_v(tr_busy, 410, 1'b1)); end
        total++; if (tr_to[410] !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b want=1", tr_to[410]); end
    endtask

    task automatic test_reset_mid;
        logic [8:0] obs;
        @(negedge clk);
        address = 10'h048; rdwl = 1'b0; asl = 1'b0; dsl = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (wizwrl !== 1'b0) begin bad++; $display("FAIL midrst_in_strobe wizwrl=%b want=0", wizwrl); end
        resetl = 1'b0;
        #1;
        obs = {dtackl, dbenl, dbdir, wizcsl, wizrdl, wizwrl, wizrst_req, busy, timeout};
        total++; if (obs !== 9'b111111000) begin bad++; $display("FAIL midrst_outputs got=%b want=%b", obs, 9'b111111000); end
        dsl = 1'b1; asl = 1'b1; rdwl = 1'b1;
        @(negedge clk);
        resetl = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_wiz_write;
        test_wiz_read;
        test_reset_reg;
        test_non_card;
        test_abort;
        test_timeout;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
